vga_fb_scanout: RTL and testbench
=================================

// Module: vga_fb_scanout
// PURPOSE
//  Downstream of the horizontal/vertical timing counters; turns h_cnt/v_cnt into framebuffer reads and VGA pixels.
//  Generates double-buffered read addresses with integer upscaling (default 320x240 -> 640x480).
//  Delays hsync/vsync/de to match RAM read latency and blanks RGB outside the visible window.
//  Swaps front/back buffer only at end of frame, on request from the render side.
// PARAMETERS
//  FB_W       320  framebuffer width in pixels; FB_W << SCALE_LOG2 must equal H_ACTIVE
//  FB_H       240  framebuffer height in lines; FB_H << SCALE_LOG2 must equal V_ACTIVE
//  SCALE_LOG2 1    log2 of the pixel/line replication factor
//  PIX_W      12   pixel width, RGB444 packed {r[11:8],g[7:4],b[3:0]}
//  RD_LAT     2    framebuffer RAM read latency in cycles (>=1), fb_addr to fb_rdata
//  ADDR_W     $clog2(FB_W*FB_H)+1  address width; the MSB selects the buffer
// PORTS
//  pix_clk    in  1       pixel clock
//  rst        in  1       asynchronous active-high reset
//  h_cnt      in  10      horizontal count from the horizontal counter
//  v_cnt      in  10      vertical count from the vertical counter
//  h_visible  in  1       h_cnt in active region
//  v_visible  in  1       v_cnt in active region
//  hsync_in   in  1       active-low hsync, aligned with h_cnt
//  vsync_in   in  1       active-low vsync, aligned with v_cnt
//  eol        in  1       1-cycle end-of-line pulse
//  eof        in  1       1-cycle end-of-frame pulse
//  swap_req   in  1       1-cycle request to swap buffers at the next eof
//  fb_rdata   in  PIX_W   RAM read data, valid RD_LAT cycles after fb_addr
//  fb_addr    out ADDR_W  {front_buf, pixel index}
//  fb_rd_en   out 1       read strobe, high for visible pixels only
//  vga_rgb    out PIX_W   output pixel, zero when de=0
//  hsync      out 1       delayed active-low hsync
//  vsync      out 1       delayed active-low vsync
//  de         out 1       delayed h_visible&&v_visible
//  front_buf  out 1       buffer currently scanned out; the writer uses ~front_buf
//  swap_ack   out 1       1-cycle pulse on the cycle front_buf changes
// BEHAVIOUR
//  Reset: fb_addr=0, fb_rd_en=0, vga_rgb=0, hsync=1, vsync=1, de=0, front_buf=0, swap_ack=0, FSM=IDLE.
//    Reset clears the row counters and loads every delay-line stage with its inactive value (sync=1, de=0).
//  Row tracking (no multiplier):
//    - eof clears row_base and line_sub to 0.
//    - eol with v_visible: line_sub++ mod 2^SCALE_LOG2; on wrap, row_base += FB_W.
//  Stage A (1 cycle):
//    - fb_addr <= {front_buf, row_base + (h_cnt>>SCALE_LOG2)}.
//    - fb_rd_en <= h_visible&&v_visible.
//    - fb_addr holds its previous value when not visible.
//  Output (1 cycle): vga_rgb <= de_pipe ? fb_rdata : 0.
//    - Total latency from counter inputs to vga_rgb/hsync/vsync/de is RD_LAT+2 cycles.
//    - All four outputs are exactly aligned.
//  Swap FSM, states IDLE/PENDING:
//    - IDLE + swap_req -> PENDING.
//    - PENDING + eof -> front_buf toggles and swap_ack=1 on the same edge, then -> IDLE.
//    - swap_req while PENDING is coalesced; it does not cause a second swap.
//    - swap_req and eof in the same cycle while IDLE: the swap happens on that eof.
//  The buffer MSB is sampled in stage A, so a frame never mixes buffers.
//  Reset mid-frame: all state returns to reset values immediately; scanout resumes at the next valid counters.
// CONFIGURATION
//  VGA_TESTPAT_EN defined:
//    - Adds input port test_mode (1 bit).
//    - With test_mode=1: fb_rd_en is forced to 0.
//    - With test_mode=1: vga_rgb = {{4{bar[2]}},{4{bar[1]}},{4{bar[0]}}}, where bar = h_cnt[8:6] delayed RD_LAT+2 cycles.
//    - vga_rgb is still zero when de=0.
//  VGA_TESTPAT_EN undefined: test_mode port absent; framebuffer path only.
// STRUCTURE
//  vga_pkg: pix_t (PIX_W vector), swap_state_e {IDLE,PENDING}, H/V timing constants shared with the counters.
//  Sub-module vga_sync_delay #(DEPTH,WIDTH): resettable shift register with a per-bit reset value.
//    It carries {hsync,vsync,de[,bar]} through RD_LAT+2 stages.
// TESTING (bench models the RAM with RD_LAT=2, data = address low bits)
//  1 Assert rst mid-line -> all outputs at reset values in the same cycle; hsync=vsync=1.
//  2 h_cnt=0, v_cnt=0 -> fb_addr=0 and fb_rd_en=1 after 1 cycle; de=1 and vga_rgb=RAM[0] after 4 cycles.
//  3 Lines v=0,1 -> row_base 0; line 2 -> fb_addr(h=0)=320; v=479, h=639 -> fb_addr=76799.
//  4 swap_req at v=100 -> front_buf 0->1 and swap_ack pulse one cycle after eof;
//    next frame fb_addr MSB=1; a second swap_req while PENDING -> a single swap only.
//  5 h_cnt=640 (blank) -> fb_rd_en=0, de=0, vga_rgb=0; hsync_in low edge reappears on hsync exactly 4 cycles later.
//  6 VGA_TESTPAT_EN, test_mode=1, h_cnt=64..127 -> vga_rgb=12'h00F four cycles later; fb_rd_en stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA types and 640x480@60 timing constants used by the scanout and the counters.
package vga_pkg;

  localparam int PIX_W_DEF = 12;
  localparam int H_ACTIVE  = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_ACTIVE  = 480;
  localparam int V_TOTAL   = 525;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

  // Colour bars: each bar index bit fills one RGB444 channel.
  function automatic pix_t bar_rgb(input logic [2:0] bar);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Resettable shift register with a per-bit reset value; exposes the last stage and the one before it.
module vga_sync_delay #(
  parameter int               DEPTH   = 4,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign tap = sr[DEPTH-2];
  assign q   = sr[DEPTH-1];

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: counters -> double-buffered upscaled reads -> aligned VGA pixels/syncs.
// Optional colour-bar test pattern with test_mode port when VGA_TESTPAT_EN is defined.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int FB_W       = H_ACTIVE >> 1,
  parameter int FB_H       = V_ACTIVE >> 1,
  parameter int SCALE_LOG2 = 1,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = $clog2(FB_W * FB_H) + 1
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              h_visible,
  input  logic              v_visible,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              eol,
  input  logic              eof,
  input  logic              swap_req,
  input  logic [PIX_W-1:0]  fb_rdata,
`ifdef VGA_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  output logic [PIX_W-1:0]  vga_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              front_buf,
  output logic              swap_ack
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_LOG2) - 1);
  localparam int DEPTH = RD_LAT + 2;
`ifdef VGA_TESTPAT_EN
  localparam int DW = 6;
`else
  localparam int DW = 3;
`endif
  // Delay-line word is {[bar,] de, vsync, hsync}; syncs idle high, de idles low.
  localparam logic [DW-1:0] DLY_RST = DW'(3'b011);

  logic [IDX_W-1:0] row_base;
  logic [SUB_W-1:0] line_sub;
  swap_state_e      swap_state;
  logic             visible;
  logic             rd_go;
  logic [DW-1:0]    dly_d;
  logic [DW-1:0]    dly_tap;
  logic [DW-1:0]    dly_q;

  assign visible = h_visible && v_visible;

  // Row tracking by accumulation; v_cnt itself is not needed.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
      line_sub <= '0;
    end else if (eof) begin
      row_base <= '0;
      line_sub <= '0;
    end else if (eol && v_visible) begin
      if (line_sub == SUB_MAX) begin
        line_sub <= '0;
        row_base <= row_base + IDX_W'(FB_W);
      end else begin
        line_sub <= line_sub + 1'b1;
      end
    end
  end

`ifdef VGA_TESTPAT_EN
  assign rd_go = visible && !test_mode;
  assign dly_d = {h_cnt[8:6], visible, vsync_in, hsync_in};
`else
  assign rd_go = visible;
  assign dly_d = {visible, vsync_in, hsync_in};
`endif

  // Stage A: the buffer MSB is taken here so a frame never mixes buffers.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
    end else begin
      fb_rd_en <= rd_go;
      if (visible) fb_addr <= {front_buf, row_base + IDX_W'(h_cnt >> SCALE_LOG2)};
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      swap_state <= IDLE;
      front_buf  <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (swap_state)
        IDLE: begin
          if (swap_req && eof) begin
            front_buf <= ~front_buf;
            swap_ack  <= 1'b1;
          end else if (swap_req) begin
            swap_state <= PENDING;
          end
        end
        PENDING: begin
          if (eof) begin
            front_buf  <= ~front_buf;
            swap_ack   <= 1'b1;
            swap_state <= IDLE;
          end
        end
        default: swap_state <= IDLE;
      endcase
    end
  end

  vga_sync_delay #(
    .DEPTH  (DEPTH),
    .WIDTH  (DW),
    .RST_VAL(DLY_RST)
  ) u_sync_delay (
    .clk(pix_clk),
    .rst(rst),
    .d  (dly_d),
    .tap(dly_tap),
    .q  (dly_q)
  );

  assign hsync = dly_q[0];
  assign vsync = dly_q[1];
  assign de    = dly_q[2];

  // Pixel register lines up with the last delay stage; tap is the de matching fb_rdata.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vga_rgb <= '0;
    end else if (!dly_tap[2]) begin
      vga_rgb <= '0;
`ifdef VGA_TESTPAT_EN
    end else if (test_mode) begin
      vga_rgb <= PIX_W'(bar_rgb(dly_tap[5:3]));
`endif
    end else begin
      vga_rgb <= fb_rdata;
    end
  end

  logic unused_sink;
`ifdef VGA_TESTPAT_EN
  assign unused_sink = ^{v_cnt, dly_tap[1:0], dly_q[DW-1:3]};
`else
  assign unused_sink = ^{v_cnt, dly_tap[1:0]};
`endif

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout; the RAM model returns the low address bits after two cycles.
module tb_vga_fb_scanout;

  localparam int ADDR_W = 18;
  localparam int PIX_W  = 12;

  logic              pix_clk = 1'b0;
  logic              rst;
  logic [9:0]        h_cnt, v_cnt;
  logic              h_visible, v_visible;
  logic              hsync_in, vsync_in;
  logic              eol, eof, swap_req;
  logic [PIX_W-1:0]  fb_rdata;
  logic [PIX_W-1:0]  ram_p1;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  logic [PIX_W-1:0]  vga_rgb;
  logic              hsync, vsync, de, front_buf, swap_ack;
`ifdef VGA_TESTPAT_EN
  logic              test_mode;
`endif

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 pix_clk = ~pix_clk;

  // two-cycle RAM model
  always @(posedge pix_clk) begin
    ram_p1   <= fb_addr[PIX_W-1:0];
    fb_rdata <= ram_p1;
  end

  vga_fb_scanout dut (
    .pix_clk  (pix_clk),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_visible(h_visible),
    .v_visible(v_visible),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .eol      (eol),
    .eof      (eof),
    .swap_req (swap_req),
    .fb_rdata (fb_rdata),
`ifdef VGA_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .fb_addr  (fb_addr),
    .fb_rd_en (fb_rd_en),
    .vga_rgb  (vga_rgb),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .front_buf(front_buf),
    .swap_ack (swap_ack)
  );

  // driver tasks: inputs change on the falling edge, outputs are read on the next falling edge
  task automatic park();
    h_cnt = 10'd700; v_cnt = 10'd500; h_visible = 1'b0; v_visible = 1'b0;
    eol = 1'b0; eof = 1'b0; swap_req = 1'b0; hsync_in = 1'b1;
  endtask

  task automatic drive(input int h, input int v, input logic l = 1'b0, input logic f = 1'b0,
                       input logic s = 1'b0, input logic hs = 1'b1);
    h_cnt = h[9:0]; v_cnt = v[9:0];
    h_visible = (h < 640); v_visible = (v < 480);
    eol = l; eof = f; swap_req = s; hsync_in = hs;
    @(negedge pix_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync_in = 1'b1; park();
    @(negedge pix_clk);
    checks++; if (hsync !== 1'b1 || de !== 1'b0 || fb_rd_en !== 1'b0) begin failures++;
      $display("FAIL rst_init got hsync=%b de=%b rd_en=%b exp 1 0 0", hsync, de, fb_rd_en); end
    @(negedge pix_clk);
    rst = 1'b0;
    drive(700, 500, 1'b0, 1'b1, 1'b1);
    checks++; if (front_buf !== 1'b1 || swap_ack !== 1'b1) begin failures++;
      $display("FAIL swap_same_cycle got front=%b ack=%b exp 1 1", front_buf, swap_ack); end
    vsync_in = 1'b0;
    for (int h = 0; h < 5; h++) drive(h, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (de !== 1'b1 || hsync !== 1'b0 || vsync !== 1'b0 || fb_addr !== 18'h20002) begin failures++;
      $display("FAIL pre_rst got de=%b hs=%b vs=%b addr=%0h exp 1 0 0 20002", de, hsync, vsync, fb_addr); end
    rst = 1'b1;
    #1;
    checks++; if (fb_addr !== '0 || fb_rd_en !== 1'b0 || vga_rgb !== '0) begin failures++;
      $display("FAIL rst_mid_data got addr=%0h rd_en=%b rgb=%0h exp 0 0 0", fb_addr, fb_rd_en, vga_rgb); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0) begin failures++;
      $display("FAIL rst_mid_sync got hs=%b vs=%b de=%b exp 1 1 0", hsync, vsync, de); end
    checks++; if (front_buf !== 1'b0 || swap_ack !== 1'b0) begin failures++;
      $display("FAIL rst_mid_swap got front=%b ack=%b exp 0 0", front_buf, swap_ack); end
    @(negedge pix_clk);
    park(); vsync_in = 1'b1;
    @(negedge pix_clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge pix_clk);
  endtask

  task automatic test_first_pixel();
    drive(0, 0);
    checks++; if (fb_addr !== 18'd0 || fb_rd_en !== 1'b1 || de !== 1'b0) begin failures++;
      $display("FAIL first_stage_a got addr=%0d rd_en=%b de=%b exp 0 1 0", fb_addr, fb_rd_en, de); end
    drive(1, 0);
    drive(2, 0);
    checks++; if (de !== 1'b0) begin failures++;
      $display("FAIL first_de_early got de=%b exp 0", de); end
    drive(3, 0);
    checks++; if (de !== 1'b1 || vga_rgb !== 12'h000 || fb_addr !== 18'd1) begin failures++;
      $display("FAIL first_de got de=%b rgb=%0h addr=%0d exp 1 0 1", de, vga_rgb, fb_addr); end
    drive(4, 0);
    drive(5, 0);
    checks++; if (vga_rgb !== 12'h001) begin failures++;
      $display("FAIL first_rgb2 got rgb=%0h exp 1", vga_rgb); end
    park();
    for (int i = 0; i < 5; i++) @(negedge pix_clk);
  endtask

  task automatic test_row_base();
    drive(799, 524, 1'b1, 1'b1);
    drive(0, 0);
    drive(799, 0, 1'b1);
    drive(0, 1);
    checks++; if (fb_addr !== 18'd0) begin failures++;
      $display("FAIL row_v1 got addr=%0d exp 0", fb_addr); end
    drive(799, 1, 1'b1);
    drive(0, 2);
    checks++; if (fb_addr !== 18'd320) begin failures++;
      $display("FAIL row_v2 got addr=%0d exp 320", fb_addr); end
    drive(1, 2);
    drive(2, 2);
    checks++; if (fb_addr !== 18'd321) begin failures++;
      $display("FAIL row_v2_h2 got addr=%0d exp 321", fb_addr); end
    drive(3, 2);
    checks++; if (vga_rgb !== 12'h140 || de !== 1'b1) begin failures++;
      $display("FAIL row_v2_rgb got rgb=%0h de=%b exp 140 1", vga_rgb, de); end
    for (int v = 2; v < 479; v++) drive(799, v, 1'b1);
    drive(639, 479);
    checks++; if (fb_addr !== 18'd76799 || fb_rd_en !== 1'b1) begin failures++;
      $display("FAIL row_last got addr=%0d rd_en=%b exp 76799 1", fb_addr, fb_rd_en); end
    drive(640, 479);
    checks++; if (fb_addr !== 18'd76799 || fb_rd_en !== 1'b0) begin failures++;
      $display("FAIL row_hold got addr=%0d rd_en=%b exp 76799 0", fb_addr, fb_rd_en); end
    park();
    for (int i = 0; i < 5; i++) @(negedge pix_clk);
  endtask

  task automatic test_swap();
    drive(5, 100, 1'b0, 1'b0, 1'b1);
    checks++; if (front_buf !== 1'b0 || swap_ack !== 1'b0) begin failures++;
      $display("FAIL swap_req_only got front=%b ack=%b exp 0 0", front_buf, swap_ack); end
    drive(6, 100);
    drive(700, 200, 1'b0, 1'b0, 1'b1);
    drive(700, 300);
    checks++; if (front_buf !== 1'b0) begin failures++;
      $display("FAIL swap_wait got front=%b exp 0", front_buf); end
    drive(799, 524, 1'b1, 1'b1);
    checks++; if (front_buf !== 1'b1 || swap_ack !== 1'b1) begin failures++;
      $display("FAIL swap_eof got front=%b ack=%b exp 1 1", front_buf, swap_ack); end
    drive(0, 0);
    checks++; if (swap_ack !== 1'b0 || fb_addr !== 18'h20000) begin failures++;
      $display("FAIL swap_next_frame got ack=%b addr=%0h exp 0 20000", swap_ack, fb_addr); end
    drive(799, 524, 1'b1, 1'b1);
    checks++; if (front_buf !== 1'b1 || swap_ack !== 1'b0) begin failures++;
      $display("FAIL swap_coalesce got front=%b ack=%b exp 1 0", front_buf, swap_ack); end
    park();
    for (int i = 0; i < 5; i++) @(negedge pix_clk);
  endtask

  task automatic test_blank();
    drive(638, 10);
    drive(639, 10);
    drive(640, 10);
    checks++; if (fb_rd_en !== 1'b0) begin failures++;
      $display("FAIL blank_rd_en got %b exp 0", fb_rd_en); end
    drive(641, 10);
    drive(642, 10);
    checks++; if (de !== 1'b1 || vga_rgb === 12'h000) begin failures++;
      $display("FAIL blank_last_vis got de=%b rgb=%0h exp de 1 rgb nonzero", de, vga_rgb); end
    drive(643, 10);
    checks++; if (de !== 1'b0 || vga_rgb !== 12'h000) begin failures++;
      $display("FAIL blank_out got de=%b rgb=%0h exp 0 0", de, vga_rgb); end
    for (int h = 644; h < 656; h++) drive(h, 10);
    drive(656, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(657, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(658, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (hsync !== 1'b1) begin failures++;
      $display("FAIL hsync_early got %b exp 1", hsync); end
    drive(659, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (hsync !== 1'b0) begin failures++;
      $display("FAIL hsync_delay got %b exp 0", hsync); end
    park();
    for (int i = 0; i < 5; i++) @(negedge pix_clk);
  endtask

`ifdef VGA_TESTPAT_EN
  task automatic test_testpat();
    test_mode = 1'b1;
    for (int h = 64; h < 72; h++) begin
      drive(h, 10);
      checks++; if (fb_rd_en !== 1'b0) begin failures++;
        $display("FAIL tp_rd_en h=%0d got %b exp 0", h, fb_rd_en); end
      if (h >= 67) begin
        checks++; if (vga_rgb !== 12'h00F || de !== 1'b1) begin failures++;
          $display("FAIL tp_rgb h=%0d got rgb=%0h de=%b exp 00f 1", h, vga_rgb, de); end
      end
    end
    park();
    for (int i = 0; i < 5; i++) @(negedge pix_clk);
    test_mode = 1'b0;
  endtask
`endif

  initial begin
`ifdef VGA_TESTPAT_EN
    test_mode = 1'b0;
`endif
    test_reset();
    test_first_pixel();
    test_row_base();
    test_swap();
    test_blank();
`ifdef VGA_TESTPAT_EN
    test_testpat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
